// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read-channel FSM state type.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_WAIT  = 2'd2,
        RD_RESP  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/axi_lite_read_slave_if.sv
// AXI4-Lite read-side bundle (AR and R channels) with master/slave views.
interface axi_lite_read_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]            ARPROT;
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;

    modport master (
        output ARVALID, ARADDR, ARPROT, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  ARVALID, ARADDR, ARPROT, RREADY,
        output ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read responder: one outstanding read, fetched from a register bank
// with 1-cycle read latency, returned on R with full RREADY backpressure.
// Optional macro AXI_LITE_RD_ERR_EN: out-of-range reads skip the bank and
// return SLVERR with zero data; without it the word index simply wraps.
module axi_lite_read_slave
    import axi_lite_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REGS   = 16,
    localparam int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_lite_read_slave_if.slave  s_axi,
    output logic                  reg_rd_en,
    output logic [IDX_W-1:0]      reg_rd_addr,
    input  logic [DATA_WIDTH-1:0] reg_rd_data
);

    rd_state_e             r_state;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rd_en;
    logic [IDX_W-1:0]      r_rd_addr;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_ar_hs;
    logic                  w_unused_bits;

    // Word index from the byte address; the two byte-lane bits are dropped.
    assign w_idx   = s_axi.ARADDR[IDX_W+1:2];
    assign w_ar_hs = s_axi.ARVALID && r_arready;

    // ARPROT and the byte-lane/high address bits carry no meaning here.
    assign w_unused_bits = &{1'b0, s_axi.ARPROT, s_axi.ARADDR};

`ifdef AXI_LITE_RD_ERR_EN
    logic w_oor;
    logic r_oor;
    assign w_oor = |s_axi.ARADDR[ADDR_WIDTH-1:IDX_W+2];
`endif

    // Read FSM: accept AR, strobe the bank, capture its data, hold R until taken.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= RD_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
`ifdef AXI_LITE_RD_ERR_EN
            r_oor     <= 1'b0;
`endif
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rd_addr <= w_idx;
`ifdef AXI_LITE_RD_ERR_EN
                        r_oor     <= w_oor;
                        r_rd_en   <= !w_oor;
`else
                        r_rd_en   <= 1'b1;
`endif
                        r_state   <= RD_FETCH;
                    end else begin
                        // Also raises ARREADY on the first edge out of reset.
                        r_arready <= 1'b1;
                    end
                end
                RD_FETCH: begin
                    r_rd_en <= 1'b0;
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
`ifdef AXI_LITE_RD_ERR_EN
                    if (r_oor) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                    end else begin
                        r_rdata <= reg_rd_data;
                        r_rresp <= RESP_OKAY;
                    end
`else
                    r_rdata <= reg_rd_data;
                    r_rresp <= RESP_OKAY;
`endif
                    r_rvalid <= 1'b1;
                    r_state  <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_axi.RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= RD_IDLE;
                    end
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

    assign s_axi.ARREADY = r_arready;
    assign s_axi.RVALID  = r_rvalid;
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;
    assign reg_rd_en     = r_rd_en;
    assign reg_rd_addr   = r_rd_addr;

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Directed bench for axi_lite_read_slave with a preloaded 16-word bank model.
module tb_axi_lite_read_slave;
    import axi_lite_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic        reg_rd_en;
    logic [3:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;

    logic [31:0] bank [16];
    int          n_checks;
    int          n_pass;
    int          n_fail;
    int          rd_en_cnt;

    axi_lite_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_read_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16)
    ) dut (
        .ACLK        (aclk),
        .ARESETn     (aresetn),
        .s_axi       (bus),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Bank model: data appears the cycle after the read strobe.
    initial reg_rd_data = '0;
    always @(posedge aclk) begin
        if (reg_rd_en) reg_rd_data <= bank[reg_rd_addr];
    end

    // Counts every cycle the strobe was high.
    initial rd_en_cnt = 0;
    always @(posedge aclk) begin
        if (reg_rd_en === 1'b1) rd_en_cnt <= rd_en_cnt + 1;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One read starting from IDLE with RREADY high; checks every stage.
    task automatic read_txn(input logic [31:0] addr, input logic [3:0] exp_idx,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp,
                            input int exp_en);
        int en_before;
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b1;
        check("arready_before_ar", {31'd0, bus.ARREADY}, 32'd1);
        en_before = rd_en_cnt;
        tick();  // edge N: AR handshake
        bus.ARVALID = 1'b0;
        check("arready_after_ar", {31'd0, bus.ARREADY}, 32'd0);
        check("rd_en_fetch", {31'd0, reg_rd_en}, exp_en);
        if (exp_en == 1) check("rd_addr_fetch", {28'd0, reg_rd_addr}, {28'd0, exp_idx});
        tick();  // edge N+1
        check("rd_en_wait", {31'd0, reg_rd_en}, 32'd0);
        check("rvalid_wait", {31'd0, bus.RVALID}, 32'd0);
        tick();  // edge N+2
        check("rvalid_resp", {31'd0, bus.RVALID}, 32'd1);
        check("rdata", bus.RDATA, exp_data);
        check("rresp", {30'd0, bus.RRESP}, {30'd0, exp_resp});
        tick();  // edge N+3 = M: R handshake
        check("rvalid_done", {31'd0, bus.RVALID}, 32'd0);
        check("arready_done", {31'd0, bus.ARREADY}, 32'd1);
        check("rd_en_pulses", rd_en_cnt - en_before, exp_en);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) bank[i] = 32'hA5A5_0000 + i;

        aresetn     = 1'b0;
        bus.ARVALID = 1'b0;
        bus.ARADDR  = '0;
        bus.ARPROT  = 3'b000;
        bus.RREADY  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_arready", {31'd0, bus.ARREADY}, 32'd0);
        check("rst_rvalid", {31'd0, bus.RVALID}, 32'd0);
        check("rst_rdata", bus.RDATA, 32'd0);
        check("rst_rresp", {30'd0, bus.RRESP}, 32'd0);
        check("rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
        check("rst_rd_addr", {28'd0, reg_rd_addr}, 32'd0);
        aresetn = 1'b1;
        tick();
        check("arready_after_rst", {31'd0, bus.ARREADY}, 32'd1);
        $display("reset release: arready=%0b", bus.ARREADY);

        // Single read
        read_txn(32'h08, 4'd2, 32'hA5A5_0002, RESP_OKAY, 1);
        $display("read 0x08 -> %h", bus.RDATA);

        // Backpressure with a second request waiting
        bus.ARADDR  = 32'h0C;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        tick();
        bus.ARADDR  = 32'h10;
        check("bp_arready_n", {31'd0, bus.ARREADY}, 32'd0);
        tick();
        tick();
        check("bp_rvalid", {31'd0, bus.RVALID}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_rvalid", {31'd0, bus.RVALID}, 32'd1);
            check("bp_hold_rdata", bus.RDATA, 32'hA5A5_0003);
            check("bp_hold_rresp", {30'd0, bus.RRESP}, 32'd0);
            check("bp_hold_arready", {31'd0, bus.ARREADY}, 32'd0);
        end
        bus.RREADY = 1'b1;
        tick();
        check("bp_rvalid_done", {31'd0, bus.RVALID}, 32'd0);
        $display("backpressure read 0x0C -> %h", 32'hA5A5_0003);
        read_txn(32'h10, 4'd4, 32'hA5A5_0004, RESP_OKAY, 1);
        $display("queued read 0x10 -> %h", bus.RDATA);

        // Back-to-back
        read_txn(32'h04, 4'd1, 32'hA5A5_0001, RESP_OKAY, 1);
        $display("b2b read 0x04 -> %h", bus.RDATA);
        read_txn(32'h3C, 4'd15, 32'hA5A5_000F, RESP_OKAY, 1);
        $display("b2b read 0x3C -> %h", bus.RDATA);

        // Out of range
`ifdef AXI_LITE_RD_ERR_EN
        read_txn(32'h40, 4'd0, 32'h0, RESP_SLVERR, 0);
`else
        read_txn(32'h40, 4'd0, 32'hA5A5_0000, RESP_OKAY, 1);
`endif
        $display("read 0x40 -> %h resp=%0d", bus.RDATA, bus.RRESP);

        // Unaligned
        read_txn(32'h07, 4'd1, 32'hA5A5_0001, RESP_OKAY, 1);
        $display("read 0x07 -> %h", bus.RDATA);

        // Reset during WAIT
        bus.ARADDR  = 32'h08;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        check("mid_rd_en_fetch", {31'd0, reg_rd_en}, 32'd1);
        tick();
        #2 aresetn = 1'b0;
        #1;
        check("wait_rst_rvalid", {31'd0, bus.RVALID}, 32'd0);
        check("wait_rst_arready", {31'd0, bus.ARREADY}, 32'd0);
        check("wait_rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
        tick();
        tick();
        #2 aresetn = 1'b1;
        tick();
        check("wait_rel_arready", {31'd0, bus.ARREADY}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("wait_rel_no_rvalid", {31'd0, bus.RVALID}, 32'd0);
        end
        $display("reset in WAIT: no stale response");

        // Reset during RESP with a pending response
        bus.ARADDR  = 32'h0C;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        tick();
        bus.ARVALID = 1'b0;
        tick();
        tick();
        check("resp_pre_rvalid", {31'd0, bus.RVALID}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("resp_rst_rvalid", {31'd0, bus.RVALID}, 32'd0);
        check("resp_rst_rdata", bus.RDATA, 32'd0);
        tick();
        #2 aresetn = 1'b1;
        tick();
        check("resp_rel_arready", {31'd0, bus.ARREADY}, 32'd1);
        check("resp_rel_rvalid", {31'd0, bus.RVALID}, 32'd0);
        $display("reset in RESP: response dropped");

        read_txn(32'h3C, 4'd15, 32'hA5A5_000F, RESP_OKAY, 1);
        $display("post-reset read 0x3C -> %h", bus.RDATA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
